toggle_sequencer: RTL and testbench

Programmable toggle sequencer for the problem-set inverter datapath. On a start request it drives `out` through a fixed number of inversions, one every `half_period+1` clock cycles, then reports completion with a one-cycle `done` pulse. It sits between the testbench or top-level control and the inverter chain, replacing the free-running `#1 clk = ~clk` stimulus with a counted, abortable, synthesizable source.

---
 rtl/toggle_sequencer.sv | 96 +++++++++
 tb/tb_toggle_sequencer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/toggle_sequencer.sv
// Counted, abortable toggle source: flips `out` n times, once every
// half_period+1 cycles, then pulses `done` for one cycle.
module toggle_sequencer #(
  parameter int unsigned CNT_W = 8,
  parameter int unsigned DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [DIV_W-1:0] half_period,
  input  logic [CNT_W-1:0] n_toggles,
  output logic             out,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] toggles_left
);

  typedef enum logic {StIdle, StRun} state_e;

  state_e           state_q, state_d;
  logic             out_q, out_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] hp_q, hp_d;

  // State register and datapath flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      out_q   <= 1'b0;
      done_q  <= 1'b0;
      rem_q   <= '0;
      div_q   <= '0;
      hp_q    <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      done_q  <= done_d;
      rem_q   <= rem_d;
      div_q   <= div_d;
      hp_q    <= hp_d;
    end
  end

  // Next-state: accept start in idle, divide and toggle while running.
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    done_d  = 1'b0;
    rem_d   = rem_q;
    div_d   = div_q;
    hp_d    = hp_q;
    unique case (state_q)
      StIdle: begin
        if (start && !abort) begin
          if (n_toggles != '0) begin
            hp_d    = half_period;
            rem_d   = n_toggles;
            div_d   = '0;
            state_d = StRun;
          end else begin
            // Zero-length request completes immediately.
            done_d = 1'b1;
          end
        end
      end
      StRun: begin
        if (abort) begin
          // Abort freezes out at its current level, even on a toggle edge.
          state_d = StIdle;
          rem_d   = '0;
          div_d   = '0;
        end else if (div_q == hp_q) begin
          out_d = ~out_q;
          rem_d = rem_q - CNT_W'(1);
          div_d = '0;
          if (rem_q == CNT_W'(1)) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign out          = out_q;
  assign busy         = (state_q == StRun);
  assign done         = done_q;
  assign toggles_left = rem_q;

endmodule

// File: tb/tb_toggle_sequencer.sv
// Self-checking bench for toggle_sequencer: directed scenarios plus random
// traffic compared against a closed-form timing model.
module tb_toggle_sequencer;

  localparam int CNT_W = 8;
  localparam int DIV_W = 8;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             abort;
  logic [DIV_W-1:0] half_period;
  logic [CNT_W-1:0] n_toggles;
  logic             out;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] toggles_left;

  int checks   = 0;
  int failures = 0;

  toggle_sequencer #(.CNT_W(CNT_W), .DIV_W(DIV_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .abort        (abort),
    .half_period  (half_period),
    .n_toggles    (n_toggles),
    .out          (out),
    .busy         (busy),
    .done         (done),
    .toggles_left (toggles_left)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a sequence is described by its start edge, period and
  // count; the number of toggles so far is elapsed edges / (hp+1).
  int   edge_num = 0;
  bit   m_run    = 0;
  bit   m_out    = 0;
  bit   m_done   = 0;
  int   m_left   = 0;
  int   m_k, m_hp, m_n;
  bit   m_base;

  task automatic model_reset();
    m_run  = 0;
    m_out  = 0;
    m_done = 0;
    m_left = 0;
  endtask

  task automatic model_edge();
    int cnt;
    edge_num++;
    if (m_run) begin
      if (abort) begin
        m_run  = 0;
        m_left = 0;
        m_done = 0;
      end else begin
        cnt = (edge_num - m_k) / (m_hp + 1);
        if (cnt > m_n) cnt = m_n;
        m_out  = m_base ^ bit'(cnt % 2);
        m_left = m_n - cnt;
        m_done = (cnt == m_n);
        if (cnt == m_n) m_run = 0;
      end
    end else begin
      m_done = 0;
      if (start && !abort) begin
        if (n_toggles == 0) begin
          m_done = 1;
        end else begin
          m_run  = 1;
          m_k    = edge_num;
          m_hp   = int'(half_period);
          m_n    = int'(n_toggles);
          m_base = m_out;
          m_left = m_n;
        end
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".out"},  32'(out),          32'(m_out));
    check({tag, ".busy"}, 32'(busy),         32'(m_run));
    check({tag, ".done"}, 32'(done),         32'(m_done));
    check({tag, ".left"}, 32'(toggles_left), 32'(m_left));
  endtask

  // One clock: model consumes the inputs seen at the edge, then compare.
  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic set_req(input bit s, input bit a, input int hp, input int n);
    start       = s;
    abort       = a;
    half_period = DIV_W'(hp);
    n_toggles   = CNT_W'(n);
  endtask

  task automatic async_reset();
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_async.out",  32'(out),          32'd0);
    check("rst_async.busy", 32'(busy),         32'd0);
    check("rst_async.done", 32'(done),         32'd0);
    check("rst_async.left", 32'(toggles_left), 32'd0);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    bit prev_out;
    int nt;
    rst_n = 1'b0;
    set_req(0, 0, 0, 0);
    #1;
    check_all("reset");
    #13 rst_n = 1'b1;
    step("idle0");

    // hp=0, n=4: out 1,0,1,0 and left 3,2,1,0 after edges k+1..k+4.
    set_req(1, 0, 0, 4);
    step("hp0_start");
    check("hp0_busy_k", 32'(busy), 32'd1);
    set_req(0, 0, 0, 0);
    for (int i = 1; i <= 4; i++) begin
      step("hp0_run");
      check("hp0_out",  32'(out),          32'(i % 2));
      check("hp0_left", 32'(toggles_left), 32'(4 - i));
    end
    check("hp0_busy_end", 32'(busy), 32'd0);
    check("hp0_done",     32'(done), 32'd1);
    step("hp0_after");
    check("hp0_done_once", 32'(done), 32'd0);

    // hp=2, n=3 from out=0: toggles at k+3, k+6, k+9.
    set_req(1, 0, 2, 3);
    step("hp2_start");
    set_req(0, 0, 0, 0);
    for (int i = 1; i <= 9; i++) begin
      step("hp2_run");
      if (i == 2) check("hp2_pre", 32'(out), 32'd0);
      if (i == 3) check("hp2_t1",  32'(out), 32'd1);
      if (i == 6) check("hp2_t2",  32'(out), 32'd0);
    end
    check("hp2_final", 32'(out),  32'd1);
    check("hp2_done",  32'(done), 32'd1);
    step("hp2_after");

    // Zero-count start pulses done; with abort it does nothing.
    set_req(1, 0, 5, 0);
    step("n0");
    check("n0_done", 32'(done), 32'd1);
    check("n0_out",  32'(out),  32'd1);
    set_req(1, 1, 5, 0);
    step("n0_abort");
    check("n0_abort_done", 32'(done), 32'd0);
    set_req(0, 0, 0, 0);
    step("n0_idle");

    // Bring out back to 0 with a single toggle.
    set_req(1, 0, 0, 1);
    step("one_start");
    set_req(0, 0, 0, 0);
    step("one_run");
    step("one_after");

    // hp=1, n=5, abort after toggle 2 (edge k+4), sampled at k+5.
    set_req(1, 0, 1, 5);
    step("ab_start");
    set_req(0, 0, 0, 0);
    for (int i = 1; i <= 4; i++) step("ab_run");
    set_req(0, 1, 0, 0);
    step("ab_edge");
    check("ab_busy", 32'(busy),         32'd0);
    check("ab_out",  32'(out),          32'd0);
    check("ab_left", 32'(toggles_left), 32'd0);
    set_req(0, 0, 0, 0);
    step("ab_after");
    check("ab_nodone", 32'(done), 32'd0);

    // start with n=7 during an n=3 run is ignored.
    set_req(1, 0, 0, 3);
    step("ign_start");
    set_req(1, 0, 0, 7);
    nt = 0;
    prev_out = out;
    for (int i = 1; i <= 6; i++) begin
      step("ign_run");
      if (i == 2) set_req(0, 0, 0, 0);
      if (out != prev_out) nt++;
      prev_out = out;
    end
    check("ign_toggles", 32'(nt), 32'd3);

    // Back-to-back: new start in the done cycle.
    set_req(1, 0, 0, 2);
    step("b2b_start");
    set_req(0, 0, 0, 0);
    step("b2b_r1");
    step("b2b_r2");
    check("b2b_done", 32'(done), 32'd1);
    set_req(1, 0, 0, 2);
    step("b2b_restart");
    check("b2b_busy", 32'(busy),         32'd1);
    check("b2b_left", 32'(toggles_left), 32'd2);
    set_req(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step("b2b_run");

    // Asynchronous reset mid-run after toggle 2 (hp=3, n=10).
    set_req(1, 0, 3, 10);
    step("rst_start");
    set_req(0, 0, 0, 0);
    for (int i = 1; i <= 9; i++) step("rst_run");
    async_reset();
    step("rst_after");

    // Maximum values.
    set_req(1, 0, 255, 2);
    step("maxhp_start");
    set_req(0, 0, 0, 0);
    for (int i = 0; i < 514; i++) step("maxhp_run");
    set_req(1, 0, 0, 255);
    step("maxn_start");
    set_req(0, 0, 0, 0);
    for (int i = 0; i < 258; i++) step("maxn_run");

    // Random traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      set_req(($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 6)));
      step("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
